// File: rtl/ysyx_22041207_mdu_ctrl_if.sv
// Bundle between the EX stage, the MDU sequencing controller and the shared
// iterative multiplier / divider units. The controller takes the slave view.
interface ysyx_22041207_mdu_ctrl_if #(
    parameter int XLEN = 64
);
    // EX request side
    logic            flush;
    logic            req_valid;
    logic [2:0]      req_op;
    logic            req_word;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            busy;
    logic            res_valid;
    logic [XLEN-1:0] res;

    // multiplier side
    logic            mul_valid;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic            mul_ready;
    logic            mul_out_valid;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;

    // divider side
    logic            div_valid;
    logic            div_signed;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic            div_ready;
    logic            div_out_valid;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;

    logic            unit_flush;
    logic [1:0]      state_dbg;

    modport slave (
        input  flush, req_valid, req_op, req_word, req_a, req_b,
        output busy, res_valid, res,
        output mul_valid, mul_signed, mul_a, mul_b,
        input  mul_ready, mul_out_valid, mul_hi, mul_lo,
        output div_valid, div_signed, div_a, div_b,
        input  div_ready, div_out_valid, div_quot, div_rem,
        output unit_flush, state_dbg
    );

    modport master (
        output flush, req_valid, req_op, req_word, req_a, req_b,
        input  busy, res_valid, res,
        input  mul_valid, mul_signed, mul_a, mul_b,
        output mul_ready, mul_out_valid, mul_hi, mul_lo,
        input  div_valid, div_signed, div_a, div_b,
        output div_ready, div_out_valid, div_quot, div_rem,
        input  unit_flush, state_dbg
    );
endinterface

// File: rtl/ysyx_22041207_mdu_ctrl.sv
// MDU sequencing controller: prepares M-extension operands, issues them to the
// shared multiplier or divider, stalls EX until the unit answers and returns an
// XLEN result. Divide-by-zero and signed overflow are answered locally.
//
// Unit handshake: a transfer happens on the rising edge where valid and ready
// are both high; valid and the operands stay stable until that edge, and the
// unit reports its result with a single-cycle out_valid pulse some time later.
module ysyx_22041207_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input logic clk,
    input logic rst,
    ysyx_22041207_mdu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = {{(XLEN-31){1'b1}}, 31'b0};

    state_t state_q, state_d;

    logic            is_div, word_eff, word_signed, div_sgn;
    logic            b_zero, ovf, special, accept;
    logic [XLEN-1:0] prep_a, prep_b, spec_raw, spec_res;
    logic [1:0]      msign;
    logic [2:0]      op_q;
    logic            word_q;
    logic            sel_ready, sel_out_valid;
    logic [XLEN-1:0] unit_raw, unit_res;

    // Word results keep only the low 32 bits, sign-extended.
    function automatic logic [XLEN-1:0] fmt_word(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Word flag only matters for MUL and the divide family; MULW/DIVW/REMW are the signed ones.
    assign is_div      = bus.req_op[2];
    assign word_eff    = bus.req_word && ((bus.req_op == 3'd0) || is_div);
    assign word_signed = !bus.req_op[0];
    assign div_sgn     = is_div && !bus.req_op[0];

    // Operand preparation for the request currently presented.
    always_comb begin
        prep_a = bus.req_a;
        prep_b = bus.req_b;
        if (word_eff) begin
            if (word_signed) begin
                prep_a = {{(XLEN-32){bus.req_a[31]}}, bus.req_a[31:0]};
                prep_b = {{(XLEN-32){bus.req_b[31]}}, bus.req_b[31:0]};
            end else begin
                prep_a = {{(XLEN-32){1'b0}}, bus.req_a[31:0]};
                prep_b = {{(XLEN-32){1'b0}}, bus.req_b[31:0]};
            end
        end
    end

    assign b_zero  = (prep_b == '0);
    assign ovf     = div_sgn && (prep_a == (word_eff ? MIN_WORD : MIN_FULL)) && (prep_b == ALL_ONES);
    assign special = is_div && (b_zero || ovf);
    assign accept  = (state_q == S_IDLE) && bus.req_valid && !bus.flush;

    // Locally resolved divide results and multiplier signedness for the request.
    always_comb begin
        spec_raw = '0;
        if (b_zero) begin
            spec_raw = bus.req_op[1] ? prep_a : ALL_ONES;
        end else if (ovf) begin
            spec_raw = bus.req_op[1] ? '0 : prep_a;
        end
        case (bus.req_op)
            3'd0, 3'd1: msign = 2'b11;
            3'd2:       msign = 2'b10;
            default:    msign = 2'b00;
        endcase
    end

    assign spec_res = fmt_word(spec_raw, word_eff);

    // Pick the handshake and result of the unit serving the latched operation.
    always_comb begin
        sel_ready     = op_q[2] ? bus.div_ready     : bus.mul_ready;
        sel_out_valid = op_q[2] ? bus.div_out_valid : bus.mul_out_valid;
        case (op_q)
            3'd0:       unit_raw = bus.mul_lo;
            3'd1, 3'd2,
            3'd3:       unit_raw = bus.mul_hi;
            3'd4, 3'd5: unit_raw = bus.div_quot;
            default:    unit_raw = bus.div_rem;
        endcase
    end

    assign unit_res = fmt_word(unit_raw, word_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush always returns to IDLE; special cases never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !special) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.flush)     state_d = S_IDLE;
                else if (sel_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.flush)          state_d = S_IDLE;
                else if (sel_out_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-derived outputs: unit valids, stall and abort.
    always_comb begin
        bus.mul_valid  = (state_q == S_ISSUE) && !op_q[2];
        bus.div_valid  = (state_q == S_ISSUE) &&  op_q[2];
        bus.busy       = !bus.flush && ((state_q != S_IDLE) || (bus.req_valid && !special));
        bus.unit_flush = bus.flush && (state_q != S_IDLE);
        bus.state_dbg  = state_q;
    end

    // Operand latches, result register and the one-cycle result pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res        <= '0;
            bus.res_valid  <= 1'b0;
            bus.mul_a      <= '0;
            bus.mul_b      <= '0;
            bus.mul_signed <= 2'b00;
            bus.div_a      <= '0;
            bus.div_b      <= '0;
            bus.div_signed <= 1'b0;
            op_q           <= 3'd0;
            word_q         <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            if (accept) begin
                if (special) begin
                    bus.res       <= spec_res;
                    bus.res_valid <= 1'b1;
                end else begin
                    op_q   <= bus.req_op;
                    word_q <= word_eff;
                    if (is_div) begin
                        bus.div_a      <= prep_a;
                        bus.div_b      <= prep_b;
                        bus.div_signed <= div_sgn;
                    end else begin
                        bus.mul_a      <= prep_a;
                        bus.mul_b      <= prep_b;
                        bus.mul_signed <= msign;
                    end
                end
            end else if ((state_q == S_WAIT) && !bus.flush && sel_out_valid) begin
                bus.res       <= unit_res;
                bus.res_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_mdu_ctrl.sv
// Bench for the MDU sequencing controller: behavioural multiplier/divider
// units with programmable latencies, directed cases, flush/reset scenarios
// and randomized operations checked against an ISA-level reference model.
module tb_ysyx_22041207_mdu_ctrl;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst;

    ysyx_22041207_mdu_ctrl_if #(.XLEN(XLEN)) bus ();

    ysyx_22041207_mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res = '0;
    int lat_r = 0;
    int lat_o = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // ISA-level reference result of one M-extension operation.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0] ua32, ub32;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        case (op)
            3'd0: begin
                p = {64'b0, a} * {64'b0, b};
                return w ? sext32(p[31:0]) : p[63:0];
            end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
            3'd4: begin
                if (w) begin
                    if (sb32 == 0) return '1;
                    if (sa32 == 32'sh80000000 && sb32 == -1) return sext32(a[31:0]);
                    return sext32(sa32 / sb32);
                end
                if (sb == 0) return '1;
                if (sa == 64'sh8000000000000000 && sb == -1) return a;
                return sa / sb;
            end
            3'd5: begin
                if (w) return (ub32 == 0) ? '1 : sext32(ua32 / ub32);
                return (b == 0) ? '1 : a / b;
            end
            3'd6: begin
                if (w) begin
                    if (sb32 == 0) return sext32(a[31:0]);
                    if (sa32 == 32'sh80000000 && sb32 == -1) return '0;
                    return sext32(sa32 % sb32);
                end
                if (sb == 0) return a;
                if (sa == 64'sh8000000000000000 && sb == -1) return '0;
                return sa % sb;
            end
            default: begin
                if (w) return (ub32 == 0) ? sext32(ua32) : sext32(ua32 % ub32);
                return (b == 0) ? a : a % b;
            end
        endcase
    endfunction

    function automatic logic word_applies(input logic [2:0] op, input logic w);
        return w && (op == 3'd0 || op >= 3'd4);
    endfunction

    // Operand the unit should receive: word signed ops sign-extend, word unsigned zero-extend.
    function automatic logic [63:0] prep(input logic [2:0] op, input logic w, input logic [63:0] v);
        if (!word_applies(op, w)) return v;
        return (op == 3'd5 || op == 3'd7) ? {32'b0, v[31:0]} : sext32(v[31:0]);
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        bit sgn;
        if (op < 3'd4) return 1'b0;
        sgn = (op == 3'd4 || op == 3'd6);
        if (w) return (b[31:0] == 32'h0) || (sgn && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
        return (b == 64'h0) || (sgn && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF);
    endfunction

    function automatic logic [1:0] exp_msign(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 2'b11;
            3'd2:       return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    // Behavioural multiplier: ready after lat_r cycles of valid, product lat_o cycles later.
    initial begin : mul_unit
        logic pend;
        int rw, ow;
        logic [127:0] prod;
        pend = 1'b0; rw = 0; ow = 0; prod = '0;
        bus.mul_ready = 1'b0; bus.mul_out_valid = 1'b0; bus.mul_hi = '0; bus.mul_lo = '0;
        forever begin
            @(negedge clk);
            bus.mul_ready     = !pend && (rw == 0);
            bus.mul_out_valid = pend && (ow == 0);
            {bus.mul_hi, bus.mul_lo} = prod;
            #4;
            if (rst || bus.unit_flush) begin
                pend = 1'b0; rw = lat_r;
            end else if (pend) begin
                if (bus.mul_out_valid) pend = 1'b0;
                else ow--;
            end else if (bus.mul_valid && bus.mul_ready) begin
                pend = 1'b1; ow = lat_o;
                prod = {{64{bus.mul_signed[1] & bus.mul_a[63]}}, bus.mul_a}
                     * {{64{bus.mul_signed[0] & bus.mul_b[63]}}, bus.mul_b};
            end else if (bus.mul_valid) begin
                rw--;
            end else begin
                rw = lat_r;
            end
        end
    end

    // Behavioural divider with the same latency knobs.
    initial begin : div_unit
        logic pend;
        int rw, ow;
        logic [63:0] q, r;
        logic signed [63:0] sa, sb;
        pend = 1'b0; rw = 0; ow = 0; q = '0; r = '0;
        bus.div_ready = 1'b0; bus.div_out_valid = 1'b0; bus.div_quot = '0; bus.div_rem = '0;
        forever begin
            @(negedge clk);
            bus.div_ready     = !pend && (rw == 0);
            bus.div_out_valid = pend && (ow == 0);
            bus.div_quot      = q;
            bus.div_rem       = r;
            #4;
            if (rst || bus.unit_flush) begin
                pend = 1'b0; rw = lat_r;
            end else if (pend) begin
                if (bus.div_out_valid) pend = 1'b0;
                else ow--;
            end else if (bus.div_valid && bus.div_ready) begin
                pend = 1'b1; ow = lat_o;
                sa = bus.div_a; sb = bus.div_b;
                if (bus.div_b == 64'h0) begin
                    q = '1; r = bus.div_a;
                end else if (bus.div_signed && sa == 64'sh8000000000000000 && sb == -1) begin
                    q = bus.div_a; r = '0;
                end else if (bus.div_signed) begin
                    q = sa / sb; r = sa % sb;
                end else begin
                    q = bus.div_a / bus.div_b; r = bus.div_a % bus.div_b;
                end
            end else if (bus.div_valid) begin
                rw--;
            end else begin
                rw = lat_r;
            end
        end
    end

    // Present one request at the current (mid-cycle) time and follow it to its result.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lr, input int lo);
        bit spec;
        logic [63:0] pa, pb;
        logic sel_v, oth_v, opnd_ok;
        int cyc, vcnt, ovcnt, bad_busy, bad_opnd;
        spec = is_special(op, w, a, b);
        pa = prep(op, w, a);
        pb = prep(op, w, b);
        lat_r = lr;
        lat_o = lo;
        exp_q.push_back(exp);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_word = w; bus.req_a = a; bus.req_b = b;
        #1;
        check("busy_req", 64'(bus.busy), 64'(!spec));
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        cyc = 1; vcnt = 0; ovcnt = 0; bad_busy = 0; bad_opnd = 0;
        if (!spec) begin
            if (op[2]) check("div_signed", 64'(bus.div_signed), 64'(!op[0]));
            else       check("mul_signed", 64'(bus.mul_signed), 64'(exp_msign(op)));
        end
        while (!bus.res_valid && cyc < 60) begin
            sel_v   = op[2] ? bus.div_valid : bus.mul_valid;
            oth_v   = op[2] ? bus.mul_valid : bus.div_valid;
            opnd_ok = op[2] ? (bus.div_a == pa && bus.div_b == pb) : (bus.mul_a == pa && bus.mul_b == pb);
            if (sel_v) vcnt++;
            if (oth_v) ovcnt++;
            if (!bus.busy) bad_busy++;
            if (sel_v && !opnd_ok) bad_opnd++;
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!bus.res_valid) begin
            check("timeout", 64'(bus.res_valid), 64'd1);
            void'(exp_q.pop_front());
            return;
        end
        check("res", bus.res, exp_q.pop_front());
        last_res = exp;
        check("busy_done", 64'(bus.busy), 64'd0);
        check("valid_at_res", 64'({bus.mul_valid, bus.div_valid}), 64'd0);
        check("latency", 64'(cyc), spec ? 64'd1 : 64'(lr + lo + 3));
        if (!spec) begin
            check("issue_cycles", 64'(vcnt), 64'(lr + 1));
            check("other_valid", 64'(ovcnt), 64'd0);
            check("stall", 64'(bad_busy), 64'd0);
            check("operands", 64'(bad_opnd), 64'd0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        bit found;
        int cnt;
        logic [2:0] op;
        logic w;
        logic [63:0] a, b;
        int mode;

        // reset
        rst = 1'b1;
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_word = 1'b0;
        bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_res", bus.res, 64'd0);
        check("rst_flags", 64'({bus.res_valid, bus.mul_valid, bus.div_valid, bus.busy, bus.unit_flush}), 64'd0);
        check("rst_operands", bus.mul_a | bus.mul_b | bus.div_a | bus.div_b, 64'd0);
        check("rst_signed", 64'({bus.mul_signed, bus.div_signed}), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // directed cases
        run_op(3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFCF, 0, 0);
        @(negedge clk);
        #1;
        check("res_valid_pulse", 64'(bus.res_valid), 64'd0);
        check("res_hold", bus.res, 64'hFFFFFFFFFFFFFFCF);
        run_op(3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'd1, 1, 2);
        run_op(3'd0, 1'b1, 64'hDEAD000000010000, 64'h0000000000008000, 64'hFFFFFFFF80000000, 0, 1);
        run_op(3'd4, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 0, 0);
        run_op(3'd7, 1'b0, 64'd123, 64'd0, 64'd123, 0, 0);
        run_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 5, 1);

        // flush in WAIT coincident with div_out_valid, with a request in the same cycle
        lat_r = 0;
        lat_o = 2;
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_word = 1'b0; bus.req_a = 64'd1000; bus.req_b = 64'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.div_out_valid) found = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("flush_reach", 64'(found), 64'd1);
        if (found) begin
            bus.flush = 1'b1;
            bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_a = 64'd55; bus.req_b = 64'd0;
            #1;
            check("flush_unit_flush", 64'(bus.unit_flush), 64'd1);
            check("flush_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
            bus.flush = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            check("flush_idle", 64'({bus.state_dbg, bus.res_valid, bus.unit_flush}), 64'd0);
            check("flush_res", bus.res, last_res);
            @(negedge clk);
            #1;
            check("flush_quiet", 64'(bus.res_valid), 64'd0);
        end
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 0, 0);

        // asynchronous reset while waiting for the multiplier
        lat_r = 0;
        lat_o = 8;
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_word = 1'b0; bus.req_a = 64'd3; bus.req_b = 64'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.state_dbg == 2'd2) found = 1'b1;
        end
        check("arst_reach_wait", 64'(found), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_res", bus.res, 64'd0);
        check("arst_flags", 64'({bus.res_valid, bus.mul_valid, bus.div_valid, bus.busy, bus.state_dbg}), 64'd0);
        check("arst_operands", bus.mul_a | bus.mul_b, 64'd0);
        check("arst_signed", 64'(bus.mul_signed), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (bus.res_valid) cnt++;
        end
        check("arst_no_res", 64'(cnt), 64'd0);

        // randomized operations, issued back-to-back
        for (int n = 0; n < 40; n++) begin
            op   = 3'($urandom_range(0, 7));
            w    = 1'($urandom_range(0, 1));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            mode = $urandom_range(0, 5);
            case (mode)
                0: b = w ? {$urandom, 32'h0} : 64'h0;
                1: begin
                    if (w) begin
                        a = {$urandom, 32'h80000000};
                        b = {$urandom, 32'hFFFFFFFF};
                    end else begin
                        a = 64'h8000000000000000;
                        b = 64'hFFFFFFFFFFFFFFFF;
                    end
                end
                2: begin
                    a = 64'($urandom_range(0, 1000));
                    b = 64'($urandom_range(1, 50));
                end
                default: ;
            endcase
            run_op(op, w, a, b, ref_mdu(op, w, a, b), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
